// File: rtl/comma_align_pkg.sv
// -----------------------------------------------------------------------------
// comma_align_pkg
// Shared types and constants for the PCS receive word aligner.
//   align_state_e : synchronization state (LOS, ACQ, SYNC)
//   COMMA_P/N     : 7-bit comma patterns (abcdeif) of both running disparities
//   K28_5_N/P     : full 10-bit K28.5 code groups (bit 9 = a)
//   is_comma7()   : true when a 7-bit slice is either comma pattern
// -----------------------------------------------------------------------------
package comma_align_pkg;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } align_state_e;

  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  localparam logic [9:0] K28_5_N = 10'b0011111010;
  localparam logic [9:0] K28_5_P = 10'b1100000101;

  function automatic logic is_comma7(input logic [6:0] bits);
    return (bits == COMMA_P) || (bits == COMMA_N);
  endfunction

endpackage

// File: rtl/comma_align_search.sv
// -----------------------------------------------------------------------------
// comma_search
// Combinational comma locator over a 20-bit window (bit 19 oldest).
// A comma at position k (0..9) occupies win[19-k -: 7]; the lowest k wins.
//   win   in  20 : {previous word, current word}
//   found out  1 : a comma exists at some k in 0..9
//   pos   out  4 : lowest matching k (0 when nothing matches)
// -----------------------------------------------------------------------------
module comma_search
  import comma_align_pkg::*;
(
  input  logic [19:0] win,
  output logic        found,
  output logic [3:0]  pos
);

  logic [9:0] match;
  genvar gi;

  generate
    for (gi = 0; gi < 10; gi++) begin : g_match
      assign match[gi] = is_comma7(win[19-gi -: 7]);
    end
  endgenerate

  // Bits 3:0 never start a 7-bit slice for k <= 9; they only matter once
  // the word shifts into the history half of the window.
  logic unused_win_lsbs;
  assign unused_win_lsbs = ^win[3:0];

  // Scan from the highest k down so the lowest matching k is left in pos.
  always_comb begin
    found = |match;
    pos   = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) pos = k[3:0];
    end
  end

endmodule

// File: rtl/comma_align.sv
// -----------------------------------------------------------------------------
// comma_align
// Word aligner for the 1G Ethernet PCS receive path, upstream of the 8b/10b
// decoder. Finds K28.5 in a 20-bit sliding window, locks a bit offset with a
// LOS/ACQ/SYNC state machine and emits aligned code groups, 1 cycle latency.
//   clk        in   1 : rising-edge clock
//   reset      in   1 : synchronous, active-low reset
//   raw_10b    in  10 : unaligned deserializer word, bit 9 received first
//   raw_valid  in   1 : raw_10b valid this cycle
//   data_10b   out 10 : aligned code group (bit 9 = a, bit 0 = j)
//   data_valid out  1 : data_10b valid
//   comma      out  1 : data_10b carries a comma
//   sync_ok    out  1 : state is SYNC
//   offset     out  4 : current alignment offset (0..9)
// Optional feature: define COMMA_ALIGN_TIMEOUT_EN to drop sync after
// COMMA_TIMEOUT valid words in SYNC without an aligned comma.
// -----------------------------------------------------------------------------
module comma_align
  import comma_align_pkg::*;
#(
  parameter int ACQ_COMMAS    = 3,
  parameter int MISALIGN_MAX  = 3,
  parameter int COMMA_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_10b,
  input  logic       raw_valid,
  output logic [9:0] data_10b,
  output logic       data_valid,
  output logic       comma,
  output logic       sync_ok,
  output logic [3:0] offset
);

  align_state_e state_reg, state_next;
  logic [9:0]   hist_reg;
  logic [2:0]   cnt_reg, cnt_next;
  logic [2:0]   miss_reg, miss_next;
  logic [3:0]   offset_reg, offset_next;
  logic [9:0]   data_10b_reg, data_10b_next;
  logic         data_valid_reg, data_valid_next;
  logic         comma_reg, comma_next;

  logic [19:0]  win;
  logic         found;
  logic [3:0]   pos;
  logic         at_offset;
  logic [9:0]   cand [10];
  logic [9:0]   aligned;

`ifdef COMMA_ALIGN_TIMEOUT_EN
  localparam int TMO_W = $clog2(COMMA_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_reg, tmo_next;
`else
  logic unused_timeout;
  assign unused_timeout = (COMMA_TIMEOUT == 0);
`endif

  assign win       = {hist_reg, raw_10b};
  assign at_offset = found && (pos == offset_reg);

  comma_search u_search (
    .win   (win),
    .found (found),
    .pos   (pos)
  );

  // Every possible 10-bit alignment of the window; the effective offset picks one.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi] = win[19-gi -: 10];
    end
  endgenerate

  // offset_next already equals the newly found position on a realigning word,
  // so the triggering comma itself comes out aligned.
  assign aligned = cand[offset_next];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= LOS;
      hist_reg       <= 10'd0;
      cnt_reg        <= 3'd0;
      miss_reg       <= 3'd0;
      offset_reg     <= 4'd0;
      data_10b_reg   <= 10'd0;
      data_valid_reg <= 1'b0;
      comma_reg      <= 1'b0;
`ifdef COMMA_ALIGN_TIMEOUT_EN
      tmo_reg        <= '0;
`endif
    end else begin
      if (raw_valid) hist_reg <= raw_10b;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      miss_reg       <= miss_next;
      offset_reg     <= offset_next;
      data_10b_reg   <= data_10b_next;
      data_valid_reg <= data_valid_next;
      comma_reg      <= comma_next;
`ifdef COMMA_ALIGN_TIMEOUT_EN
      tmo_reg        <= tmo_next;
`endif
    end
  end

  // Next-state logic; everything holds on words with raw_valid low.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    miss_next   = miss_reg;
    offset_next = offset_reg;
`ifdef COMMA_ALIGN_TIMEOUT_EN
    tmo_next    = tmo_reg;
`endif
    if (raw_valid) begin
      unique case (state_reg)
        LOS: begin
          if (found) begin
            state_next  = ACQ;
            offset_next = pos;
            cnt_next    = 3'd1;
          end
        end
        ACQ: begin
          if (at_offset) begin
            cnt_next = cnt_reg + 3'd1;
            if (cnt_next == 3'(ACQ_COMMAS)) begin
              state_next = SYNC;
              miss_next  = 3'd0;
`ifdef COMMA_ALIGN_TIMEOUT_EN
              tmo_next   = '0;
`endif
            end
          end else if (found) begin
            offset_next = pos;
            cnt_next    = 3'd1;
          end
        end
        SYNC: begin
          if (at_offset) begin
            miss_next = 3'd0;
          end else if (found) begin
            miss_next = miss_reg + 3'd1;
            if (miss_next == 3'(MISALIGN_MAX)) state_next = LOS;
          end
`ifdef COMMA_ALIGN_TIMEOUT_EN
          if (at_offset) begin
            tmo_next = '0;
          end else begin
            tmo_next = tmo_reg + 1'b1;
            if (tmo_next == TMO_W'(COMMA_TIMEOUT)) state_next = LOS;
          end
`endif
        end
        default: state_next = LOS;
      endcase
    end
  end

  // Output logic
  always_comb begin
    data_valid_next = raw_valid && ((state_reg != LOS) || found);
    data_10b_next   = raw_valid ? aligned : data_10b_reg;
    comma_next      = raw_valid ? is_comma7(aligned[9:3]) : comma_reg;
  end

  assign data_10b   = data_10b_reg;
  assign data_valid = data_valid_reg;
  assign comma      = comma_reg;
  assign sync_ok    = (state_reg == SYNC);
  assign offset     = offset_reg;

endmodule

// File: tb/tb_comma_align.sv
// -----------------------------------------------------------------------------
// tb_comma_align
// Self-checking bench for comma_align: a table of hand-derived vectors for an
// aligned stream, hand-built bit-level sequences for realignment corners, and
// a randomized stream checked against a behavioural model of the aligner.
// -----------------------------------------------------------------------------
module tb_comma_align;
  import comma_align_pkg::*;

`ifdef COMMA_ALIGN_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 1023;
`endif
  localparam int TB_ACQ = 3;
  localparam int TB_MIS = 3;
  localparam logic [9:0] D16_2 = 10'b1001000101;

  localparam int M_HUNT = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] raw_10b = 10'd0;
  logic       raw_valid = 1'b0;
  logic [9:0] data_10b;
  logic       data_valid;
  logic       comma;
  logic       sync_ok;
  logic [3:0] offset;

  always #5 clk = ~clk;

  comma_align #(
    .ACQ_COMMAS    (TB_ACQ),
    .MISALIGN_MAX  (TB_MIS),
    .COMMA_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_10b    (raw_10b),
    .raw_valid  (raw_valid),
    .data_10b   (data_10b),
    .data_valid (data_valid),
    .comma      (comma),
    .sync_ok    (sync_ok),
    .offset     (offset)
  );

  int errors = 0;
  int checks = 0;
  int drops  = 0;

  // Behavioural model state
  int         m_mode, m_off, m_cnt, m_miss, m_idle;
  logic [9:0] m_hist, e_data;
  logic       e_dv, e_comma;

  bit bq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_c7(input int v);
    return (v == 'h1F) || (v == 'h60);
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_off = 0; m_cnt = 0; m_miss = 0; m_idle = 0;
    m_hist = 10'd0; e_data = 10'd0; e_dv = 1'b0; e_comma = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [9:0] w);
    int win, kpos, eff;
    bit fnd;
    if (!v) begin
      e_dv = 1'b0;
      return;
    end
    win = int'({m_hist, w});
    fnd = 0;
    kpos = 0;
    for (int k = 0; k < 10; k++)
      if (!fnd && is_c7((win >> (13 - k)) & 'h7F)) begin
        fnd = 1;
        kpos = k;
      end
    eff = m_off;
    e_dv = (m_mode != M_HUNT) || fnd;
    if (m_mode == M_HUNT) begin
      if (fnd) begin
        m_mode = M_ACQ; m_off = kpos; m_cnt = 1; eff = kpos;
      end
    end else if (m_mode == M_ACQ) begin
      if (fnd && kpos == m_off) begin
        m_cnt++;
        if (m_cnt == TB_ACQ) begin
          m_mode = M_LOCK; m_miss = 0; m_idle = 0;
        end
      end else if (fnd) begin
        m_off = kpos; m_cnt = 1; eff = kpos;
      end
    end else begin
      if (fnd && kpos == m_off) begin
        m_miss = 0; m_idle = 0;
      end else begin
        m_idle++;
        if (fnd) begin
          m_miss++;
          if (m_miss == TB_MIS) m_mode = M_HUNT;
        end
`ifdef COMMA_ALIGN_TIMEOUT_EN
        if (m_idle == TB_TIMEOUT) m_mode = M_HUNT;
`endif
      end
    end
    e_data  = 10'((win >> (10 - eff)) & 'h3FF);
    e_comma = is_c7(int'(e_data) >> 3);
    m_hist  = w;
  endtask

  // One clock: drive a word, advance the model, compare after the edge.
  task automatic cyc(input logic v, input logic [9:0] w);
    raw_valid = v;
    raw_10b   = w;
    model_step(v, w);
    @(posedge clk);
    #1;
    chk("data_valid", data_valid, e_dv);
    chk("data_10b", data_10b, e_data);
    chk("comma", comma, e_comma);
    chk("sync_ok", sync_ok, m_mode == M_LOCK);
    chk("offset", offset, m_off);
    if (!sync_ok) drops++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    raw_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data_10b", data_10b, 0);
    chk("rst_comma", comma, 0);
    chk("rst_sync_ok", sync_ok, 0);
    chk("rst_offset", offset, 0);
    reset = 1'b1;
    bq.delete();
  endtask

  task automatic push_bits(input int n, input int pattern);
    for (int i = n - 1; i >= 0; i--) bq.push_back(pattern[i]);
  endtask

  task automatic push_kd(input int pairs);
    for (int p = 0; p < pairs; p++) begin
      push_bits(10, int'(K28_5_N));
      push_bits(10, int'(D16_2));
    end
  endtask

  task automatic send_queued(input bit gaps);
    logic [9:0] w;
    while (bq.size() >= 10) begin
      if (gaps && $urandom_range(0, 7) == 0) cyc(1'b0, 10'($urandom()));
      for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
      cyc(1'b1, w);
    end
  endtask

  typedef struct {
    logic       v;
    logic [9:0] w;
    logic       dv;
    logic [9:0] d;
    logic       c;
    logic       s;
    logic [3:0] o;
  } vec_t;

  vec_t tv[9];

  initial begin
    // Aligned K28.5/D16.2 stream at offset 0; output is the previous valid word.
    tv[0] = '{1'b1, K28_5_N, 1'b0, 10'd0,   1'b0, 1'b0, 4'd0};
    tv[1] = '{1'b1, D16_2,   1'b1, K28_5_N, 1'b1, 1'b0, 4'd0};
    tv[2] = '{1'b1, K28_5_N, 1'b1, D16_2,   1'b0, 1'b0, 4'd0};
    tv[3] = '{1'b1, D16_2,   1'b1, K28_5_N, 1'b1, 1'b0, 4'd0};
    tv[4] = '{1'b0, 10'h3FF, 1'b0, K28_5_N, 1'b1, 1'b0, 4'd0};
    tv[5] = '{1'b1, K28_5_N, 1'b1, D16_2,   1'b0, 1'b0, 4'd0};
    tv[6] = '{1'b1, D16_2,   1'b1, K28_5_N, 1'b1, 1'b1, 4'd0};
    tv[7] = '{1'b1, K28_5_N, 1'b1, D16_2,   1'b0, 1'b1, 4'd0};
    tv[8] = '{1'b1, D16_2,   1'b1, K28_5_N, 1'b1, 1'b1, 4'd0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      raw_valid = tv[i].v;
      raw_10b   = tv[i].w;
      model_step(tv[i].v, tv[i].w);
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_dv", i), data_valid, tv[i].dv);
      chk($sformatf("tv%0d_data", i), data_10b, tv[i].d);
      chk($sformatf("tv%0d_comma", i), comma, tv[i].c);
      chk($sformatf("tv%0d_sync", i), sync_ok, tv[i].s);
      chk($sformatf("tv%0d_offset", i), offset, tv[i].o);
      $display("tv%0d: valid=%0b raw=%b -> dv=%0b data=%b comma=%0b sync=%0b off=%0d",
               i, tv[i].v, tv[i].w, data_valid, data_10b, comma, sync_ok, offset);
    end

    // Three consecutive commas at offset 2 while in SYNC: sync is lost.
    drops = 0;
    bq.delete();
    push_bits(2, 'b10);
    push_kd(3);
    send_queued(1'b0);
    chk("misalign3_lost_sync", drops > 0, 1);
    $display("misalign x3: sync_ok=%0b offset=%0d", sync_ok, offset);

    // Two misaligned, one aligned, one misaligned: sync is kept.
    do_reset();
    push_kd(4);
    send_queued(1'b0);
    chk("resync_offset0", sync_ok, 1);
    drops = 0;
    push_bits(2, 'b10);
    push_kd(2);
    push_bits(8, 'b10101010);
    push_kd(1);
    push_bits(2, 'b10);
    push_kd(1);
    for (int i = 0; i < 3; i++) push_bits(10, int'(D16_2));
    send_queued(1'b0);
    chk("misalign_recovered_drops", drops, 0);
    $display("misalign x2+aligned+x1: sync_ok=%0b offset=%0d", sync_ok, offset);

    // ACQ restart: two commas at offset 0, then the stream slips to offset 7.
    do_reset();
    push_kd(2);
    send_queued(1'b0);
    push_bits(7, 'b1010101);
    push_kd(2);
    send_queued(1'b0);
    chk("acq_restart_offset", offset, 7);
    chk("acq_restart_not_sync", sync_ok, 0);
    push_kd(1);
    send_queued(1'b0);
    chk("acq_restart_sync", sync_ok, 1);
    chk("acq_restart_offset_final", offset, 7);
    $display("acq restart: sync_ok=%0b offset=%0d", sync_ok, offset);

    // Stream rotated by 4 bits.
    do_reset();
    push_bits(4, 'b1010);
    push_kd(5);
    send_queued(1'b0);
    chk("rot4_offset", offset, 4);
    chk("rot4_sync", sync_ok, 1);
    $display("rotate 4: sync_ok=%0b offset=%0d data=%b", sync_ok, offset, data_10b);

    // Reset pulled mid-SYNC, then reacquire from LOS.
    do_reset();
    push_kd(4);
    send_queued(1'b0);
    chk("reacquire_sync", sync_ok, 1);
    chk("reacquire_offset", offset, 0);
    $display("reset+reacquire: sync_ok=%0b offset=%0d", sync_ok, offset);

`ifdef COMMA_ALIGN_TIMEOUT_EN
    // Timeout of 8 valid non-comma words, with a 5-cycle valid gap inside.
    do_reset();
    push_kd(3);
    send_queued(1'b0);
    chk("tmo_enter_sync", sync_ok, 1);
    for (int i = 0; i < 4; i++) cyc(1'b1, D16_2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 10'($urandom()));
    for (int i = 0; i < 3; i++) cyc(1'b1, D16_2);
    chk("tmo_still_sync_after7", sync_ok, 1);
    cyc(1'b1, D16_2);
    chk("tmo_lost_sync_on8", sync_ok, 0);
    $display("timeout: sync_ok=%0b", sync_ok);
`endif

    // Randomized mix of comma pairs and random bit slips, with valid gaps.
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int p = 0; p < int'($urandom_range(1, 5)); p++) begin
          push_bits(10, ($urandom_range(0, 1) != 0) ? int'(K28_5_N) : int'(K28_5_P));
          push_bits(10, int'(D16_2));
        end
      end else begin
        push_bits(int'($urandom_range(1, 13)), int'($urandom()));
      end
      send_queued(1'b1);
      $display("random seg %0d: sync_ok=%0b offset=%0d", seg, sync_ok, offset);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
